seq_restoring_divider: RTL
==========================

// Module: seq_restoring_divider
// PURPOSE
//   Multi-cycle unsigned restoring divider. It is the inverse of the ripple adder datapath:
//   each iteration performs a trial subtraction, built as a ripple of full adders with the
//   divisor inverted and carry-in = 1, then restores or keeps the partial remainder.
//   Used by the TPU post-processing path for normalisation and averaging.
//   Valid/ready handshake on both the operand side and the result side.
// PARAMETERS
//   WIDTH   16   operand, quotient and remainder width in bits (>= 2)
// PORTS
//   clk          in   1      rising-edge clock
//   rst          in   1      synchronous, active-high reset
//   in_valid     in   1      operands present on dividend/divisor
//   in_ready     out  1      divider idle and able to accept operands
//   dividend     in   WIDTH  numerator, sampled on the accept edge
//   divisor      in   WIDTH  denominator, sampled on the accept edge
//   out_valid    out  1      quotient/remainder/div_by_zero are valid
//   out_ready    in   1      consumer accepts the result
//   quotient     out  WIDTH  registered quotient
//   remainder    out  WIDTH  registered remainder
//   div_by_zero  out  1      result came from divisor == 0
// BEHAVIOUR
//   - Reset values: state IDLE, in_ready=1, out_valid=0, quotient=0, remainder=0,
//     div_by_zero=0, iteration counter 0. rst overrides every other input.
//   - FSM states:
//       IDLE: in_ready=1. On in_valid&&in_ready, latch the operands.
//             divisor==0 -> go to DONE; otherwise go to CALC with count=0.
//       CALC: one iteration per clock; count increments; after iteration WIDTH-1 go to DONE.
//       DONE: out_valid=1, in_ready=0. On out_ready, go to IDLE.
//   - Iteration rule: P = {R[WIDTH-2:0], Q[WIDTH-1]}; Q shifts left by one bit.
//       T = P + ~D + 1, computed in WIDTH+1 bits.
//       Carry-out = 1 (no borrow): R = T[WIDTH-1:0], new Q LSB = 1.
//       Otherwise: R = P, new Q LSB = 0.
//   - Remainder register: WIDTH+1 bits internally, so no bit is lost on the shift.
//     The remainder port is the low WIDTH bits.
//   - Latency: out_valid rises after the WIDTH-th edge following the accept edge.
//     The divide-by-zero path takes 1 edge.
//   - Divide-by-zero result: quotient = all ones, remainder = dividend, div_by_zero = 1.
//   - Results and out_valid hold stable while out_ready=0 (back-pressure, unbounded).
//   - in_ready=0 outside IDLE. in_valid is ignored in CALC and DONE; there is no queueing.
//   - Operands are captured at accept. Input changes during CALC have no effect.
//   - DONE with out_ready=1: return to IDLE, in_ready=1 on the next cycle.
//     There is no same-cycle result-out / operands-in overlap.
//   - Reset mid-CALC or mid-DONE: abort with no result. Reset values are visible after
//     the reset edge.
//   - quotient/remainder/div_by_zero update only on the edge that enters DONE.
// CONFIGURATION
//   DIV_SIGNED_EN defined: two's-complement signed division.
//     - Operands are converted to magnitudes at accept.
//     - Quotient is negated when the operand signs differ.
//     - Remainder takes the sign of the dividend (truncating division).
//     - Fix-up happens on the DONE-entry edge; latency is unchanged.
//     - MIN_INT / -1 -> quotient = MIN_INT (wraps), remainder = 0, no flag.
//     - Divide by zero: quotient = -1, remainder = dividend, div_by_zero = 1.
//   DIV_SIGNED_EN undefined: purely unsigned; no sign logic is synthesised.
// TESTING (WIDTH=16)
//   - 100 / 7 -> out_valid 16 edges after accept; quotient=14, remainder=2,
//     div_by_zero=0.
//   - 5 / 0 -> out_valid 1 edge after accept; quotient=16'hFFFF, remainder=5,
//     div_by_zero=1.
//   - 16'hFFFF / 1 -> quotient=16'hFFFF, remainder=0.
//     16'h0003 / 16'h0009 -> quotient=0, remainder=3.
//   - Hold out_ready=0 for 5 cycles after out_valid -> outputs stable, in_ready=0,
//     a pulsed in_valid is ignored.
//     Raise out_ready -> next cycle out_valid=0, in_ready=1.
//   - Assert rst at CALC iteration 8 -> next cycle in_ready=1, out_valid=0, outputs 0.
//     Then 1000 / 10 -> quotient=100, remainder=0.
//   - DIV_SIGNED_EN: -7 / 2 -> quotient=16'hFFFD, remainder=16'hFFFF.
//     16'h8000 / 16'hFFFF -> quotient=16'h8000, remainder=0.

Source files
------------

// File: rtl/seq_restoring_divider.sv
// rtl/seq_restoring_divider.sv - multi-cycle restoring divider, valid/ready on both sides
// Optional signed mode: define DIV_SIGNED_EN for two's-complement truncating division.
module seq_restoring_divider #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);
    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t           state_q;
    logic [CW-1:0]    count_q;
    logic [WIDTH:0]   r_q;
    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] d_q;
    logic             in_ready_q;
    logic             out_valid_q;
    logic [WIDTH-1:0] quotient_q;
    logic [WIDTH-1:0] remainder_q;
    logic             dbz_q;

    logic [WIDTH:0]   p;
    logic [WIDTH:0]   db;
    logic [WIDTH:0]   t;
    logic [WIDTH+1:0] c;
    logic             no_borrow;
    logic [WIDTH:0]   r_d;
    logic [WIDTH-1:0] q_d;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [WIDTH-1:0] q_fix;
    logic [WIDTH-1:0] r_fix;
    logic             unused_r_msb;

    // The remainder never exceeds the divisor, so its top bit only matters inside P.
    assign unused_r_msb = r_q[WIDTH];

    // Trial subtraction as a ripple of full adders: P + ~D + 1.
    always_comb begin
        p    = {r_q[WIDTH-1:0], q_q[WIDTH-1]};
        db   = ~{1'b0, d_q};
        c    = '0;
        t    = '0;
        c[0] = 1'b1;
        for (int i = 0; i <= WIDTH; i++) begin
            t[i]   = p[i] ^ db[i] ^ c[i];
            c[i+1] = (p[i] & db[i]) | (p[i] & c[i]) | (db[i] & c[i]);
        end
        no_borrow = c[WIDTH+1];
        r_d       = no_borrow ? t : p;
        q_d       = {q_q[WIDTH-2:0], no_borrow};
    end

`ifdef DIV_SIGNED_EN
    logic q_neg_q;
    logic r_neg_q;

    always_comb begin
        a_mag = dividend[WIDTH-1] ? (~dividend + 1'b1) : dividend;
        b_mag = divisor[WIDTH-1]  ? (~divisor + 1'b1)  : divisor;
        q_fix = q_neg_q ? (~q_d + 1'b1) : q_d;
        r_fix = r_neg_q ? (~r_d[WIDTH-1:0] + 1'b1) : r_d[WIDTH-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q_neg_q <= 1'b0;
            r_neg_q <= 1'b0;
        end else if (state_q == IDLE && in_valid) begin
            q_neg_q <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
            r_neg_q <= dividend[WIDTH-1];
        end
    end
`else
    always_comb begin
        a_mag = dividend;
        b_mag = divisor;
        q_fix = q_d;
        r_fix = r_d[WIDTH-1:0];
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            count_q     <= '0;
            r_q         <= '0;
            q_q         <= '0;
            d_q         <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        in_ready_q <= 1'b0;
                        if (divisor == '0) begin
                            state_q     <= DONE;
                            out_valid_q <= 1'b1;
                            quotient_q  <= '1;
                            remainder_q <= dividend;
                            dbz_q       <= 1'b1;
                        end else begin
                            state_q <= CALC;
                            count_q <= '0;
                            r_q     <= '0;
                            q_q     <= a_mag;
                            d_q     <= b_mag;
                        end
                    end
                end
                CALC: begin
                    r_q     <= r_d;
                    q_q     <= q_d;
                    count_q <= count_q + 1'b1;
                    if (count_q == CW'(WIDTH - 1)) begin
                        state_q     <= DONE;
                        out_valid_q <= 1'b1;
                        quotient_q  <= q_fix;
                        remainder_q <= r_fix;
                        dbz_q       <= 1'b0;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_q     <= IDLE;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready    = in_ready_q;
    assign out_valid   = out_valid_q;
    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign div_by_zero = dbz_q;
endmodule
